// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port 160x120x8 framebuffer RAM between the
// VGA scan-out (hard priority, slot 0 of each pixel period) and a single pixel
// writer that fills every other memory cycle. Produces the 4x4-upscaled pixel
// for the 640x480 visible area.
module vga_fb_arbiter #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int H_VIS_START = 144,
  parameter int V_VIS_START = 35
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic [15:0] haddress,
  input  logic [15:0] vaddress,
  input  logic        wr_req,
  input  logic [14:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  output logic        wr_err,
  output logic [14:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  pixel_out,
  output logic        frame_start
);

  localparam int FB_SIZE   = FB_W * FB_H;
  localparam int H_VIS_LEN = FB_W * 4;
  localparam int V_VIS_LEN = FB_H * 4;

  // Slot counter: forced to 0 by pix_ce, then counts up and parks at 3 so a
  // late pix_ce never produces a spurious display slot.
  logic [1:0]  slot_q, slot_cur, slot_nxt;

  // Last presented address/data, held through idle cycles.
  logic [14:0] addr_q;
  logic [7:0]  wdata_q;

  logic        err_q;
  logic        disp_pend;   // a display read was issued last cycle
  logic        load_pend;   // a slot-0 cycle happened last cycle
  logic [7:0]  pix_q;

  // Visible-area position relative to the first visible count.
  logic [15:0] hx, vy;
  logic        h_vis, v_vis, visible;
  logic [7:0]  col;
  logic [6:0]  row;
  logic [14:0] disp_addr;
  logic        unused_bits;

  logic        disp_rd;
  logic        wr_go;
  logic        wr_ok;

  assign hx = haddress - 16'(H_VIS_START);
  assign vy = vaddress - 16'(V_VIS_START);

  // Subtraction wraps below the start count, so the lower bound is checked
  // on the raw count and the upper bound on the offset.
  assign h_vis   = (haddress >= 16'(H_VIS_START)) && (hx < 16'(H_VIS_LEN));
  assign v_vis   = (vaddress >= 16'(V_VIS_START)) && (vy < 16'(V_VIS_LEN));
  assign visible = h_vis && v_vis;

  // Quarter-resolution coordinates; only meaningful while visible.
  assign col = hx[9:2];
  assign row = vy[8:2];

  // row*160 + col built from shifts to avoid a multiplier.
  assign disp_addr = ({8'd0, row} << 7) + ({8'd0, row} << 5) + {7'd0, col};

  assign unused_bits = ^{hx[15:10], hx[1:0], vy[15:9], vy[1:0]};

  // Slot 0 is the pix_ce cycle itself; the register tracks the following slots.
  assign slot_cur = pix_ce ? 2'd0 : slot_q;
  assign slot_nxt = (slot_cur == 2'd3) ? 2'd3 : slot_cur + 2'd1;

  // Display read owns slot 0 when visible; the writer takes any other cycle.
  assign disp_rd = !rst && pix_ce && visible;
  assign wr_go   = !rst && wr_req && !disp_rd;
  assign wr_ok   = (wr_addr < 15'(FB_SIZE));

  // Memory port and handshake outputs, resolved in the same cycle as the request.
  always_comb begin
    wr_ack      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    frame_start = 1'b0;
    if (rst) begin
      mem_addr  = 15'd0;
      mem_wdata = 8'd0;
    end else begin
      frame_start = pix_ce && (haddress == 16'd0) && (vaddress == 16'd0);
      if (disp_rd) begin
        mem_addr = disp_addr;
      end else if (wr_go) begin
        wr_ack = 1'b1;
        if (wr_ok) begin
          mem_we    = 1'b1;
          mem_addr  = wr_addr;
          mem_wdata = wr_data;
        end
      end
    end
  end

  // Slot counter, held address/data, sticky error and read-pipeline flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q    <= 2'd3;
      addr_q    <= 15'd0;
      wdata_q   <= 8'd0;
      err_q     <= 1'b0;
      disp_pend <= 1'b0;
      load_pend <= 1'b0;
    end else begin
      slot_q    <= slot_nxt;
      addr_q    <= mem_addr;
      wdata_q   <= mem_wdata;
      disp_pend <= disp_rd;
      load_pend <= pix_ce;
      if (wr_go && !wr_ok) err_q <= 1'b1;
    end
  end

  // Pixel register: RAM data one cycle after a display read, black after a
  // blanking slot 0, otherwise held for the rest of the pixel period.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q <= 8'd0;
    end else if (load_pend) begin
      pix_q <= disp_pend ? mem_rdata : 8'd0;
    end
  end

  assign pixel_out = pix_q;
  assign wr_err    = err_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a synchronous-read RAM model.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_ce;
  logic [15:0] haddress, vaddress;
  logic        wr_req;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack, wr_err, mem_we, frame_start;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata, pixel_out;

  vga_fb_arbiter dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .haddress(haddress), .vaddress(vaddress),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .wr_err(wr_err), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pixel_out(pixel_out), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:19199];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Writer model state and per-cycle samples.
  logic        wr_on = 1'b0;
  logic        wr_auto = 1'b1;
  logic [14:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int acks, slot0_we, fs_cnt;
  logic        ack_s, we_s, fs_s;
  logic [14:0] addr_s, addr0;
  logic        we0;
  logic [7:0]  px_s;

  function automatic logic [7:0] wdat(input logic [14:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // One clk cycle: drive after posedge, sample at negedge.
  task automatic cyc(input logic ce, input logic [15:0] h, input logic [15:0] v);
    logic got_ack;
    pix_ce = ce; haddress = h; vaddress = v; wr_req = wr_on;
    @(negedge clk);
    ack_s = wr_ack; we_s = mem_we; addr_s = mem_addr; px_s = pixel_out; fs_s = frame_start;
    if (fs_s) fs_cnt++;
    got_ack = wr_on && wr_ack;
    if (got_ack) begin
      acks++;
      if (mem_we) begin
        if (ce) slot0_we++;
        wa_q.push_back(wr_addr);
        wd_q.push_back(wr_data);
      end
    end
    @(posedge clk); #1;
    if (got_ack && wr_auto) begin
      wr_addr = wr_addr + 15'd1;
      wr_data = wdat(wr_addr);
    end
  endtask

  // One pixel period; px_s after the third cycle is the pixel for (h,v).
  logic [7:0] px_per;
  task automatic pix(input logic [15:0] h, input logic [15:0] v);
    acks = 0; slot0_we = 0; fs_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(i == 0, h, v);
      if (i == 0) begin addr0 = addr_s; we0 = we_s; end
      if (i == 2) px_per = px_s;
    end
  endtask

  initial begin
    for (int i = 0; i < 19200; i++) ram[i] = 8'h00;
    ram[0] = 8'h11; ram[1] = 8'h22; ram[19199] = 8'h3C;

    // Reset with a pending write and a would-be visible slot 0.
    rst = 1'b1; pix_ce = 1'b1; haddress = 16'd144; vaddress = 16'd35;
    wr_on = 1'b1; wr_req = 1'b1; wr_addr = 15'd500; wr_data = 8'h77;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_outs", {wr_ack, mem_we, wr_err, frame_start, pixel_out, mem_addr, mem_wdata},
          32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    wr_auto = 1'b0;
    cyc(1'b0, 16'd0, 16'd10);
    chk("first_grant", {ack_s, we_s, addr_s}, {1'b1, 1'b1, 15'd500});
    wr_on = 1'b0; wr_auto = 1'b1;

    // Idle: address held, no write.
    cyc(1'b0, 16'd0, 16'd10);
    chk("idle_hold", {we_s, addr_s}, {1'b0, 15'd500});

    // Visible scan, writer idle.
    for (int h = 144; h < 152; h++) begin
      pix(16'(h), 16'd35);
      chk("scan_px", px_per, (h < 148) ? 32'h11 : 32'h22);
    end

    // Contention in the visible area.
    wr_on = 1'b1; wr_addr = 15'd1000; wr_data = wdat(15'd1000);
    for (int h = 152; h < 158; h++) begin
      pix(16'(h), 16'd36);
      chk("vis_acks", acks, 3);
      chk("vis_slot0_we", slot0_we, 0);
    end

    // Blanking: black pixel, four grants per period.
    for (int i = 0; i < 3; i++) begin
      pix(16'd50, 16'd100);
      chk("blank_px", px_per, 0);
      chk("blank_acks", acks, 4);
    end

    // Late pix_ce: writer keeps getting every cycle.
    acks = 0;
    for (int i = 0; i < 6; i++) cyc(1'b0, 16'd50, 16'd100);
    chk("late_acks", acks, 6);
    wr_on = 1'b0;
    cyc(1'b0, 16'd50, 16'd100);

    // Readback of everything written.
    chk("wr_count", wa_q.size(), 1 + 18 + 12 + 6);
    chk("rb_500", ram[500], 32'h77);
    for (int i = 0; i < wa_q.size(); i++) chk("readback", ram[wa_q[i]], wd_q[i]);

    // Address and frame corners.
    pix(16'd783, 16'd514);
    chk("corner_addr", {we0, addr0}, {1'b0, 15'd19199});
    chk("corner_px", px_per, 32'h3C);
    pix(16'd0, 16'd0);
    chk("frame_pulse", fs_cnt, 1);
    pix(16'd1, 16'd0);
    chk("frame_none", fs_cnt, 0);

    // Out-of-range write.
    wr_on = 1'b1; wr_auto = 1'b0; wr_addr = 15'd19200; wr_data = 8'hEE;
    cyc(1'b0, 16'd50, 16'd100);
    chk("oor_ack", {ack_s, we_s}, 2'b10);
    wr_on = 1'b0;
    cyc(1'b0, 16'd50, 16'd100);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'd50, 16'd100);
    chk("oor_sticky", wr_err, 1);
    rst = 1'b1;
    cyc(1'b0, 16'd50, 16'd100);
    rst = 1'b0;
    cyc(1'b0, 16'd50, 16'd100);
    chk("err_cleared", wr_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Framebuffer access arbiter for the VGA display path. It shares a single-port 160x120, 8-bit-per-pixel framebuffer RAM between the display scan-out, which has hard real-time priority, and one pixel writer such as a drawing engine or CPU. It takes the horizontal and vertical counts produced by the VGA timing block and returns the 4x4-upscaled pixel for the 640x480 visible area. Writer accesses are interleaved into the free memory slots.

## Interface
- `FB_W`, default 160: framebuffer width in pixels.
- `FB_H`, default 120: framebuffer height in pixels.
- `H_VIS_START`, default 144: first visible horizontal count (sync 96 + back porch 48).
- `V_VIS_START`, default 35: first visible vertical count (sync 2 + back porch 33).
- `clk` input, 1 bit: system clock, 4x the pixel rate. Single clock domain.
- `rst` input, 1 bit: synchronous, active-high reset.
- `pix_ce` input, 1 bit: one-cycle pulse per pixel period, aligned to the timing-block counter update.
- `haddress` input, 16 bits: horizontal count, 0..799.
- `vaddress` input, 16 bits: vertical count, 0..524.
- `wr_req` input, 1 bit: writer request. Held high until acknowledged.
- `wr_addr` input, 15 bits: linear framebuffer address. Must be stable while `wr_req` is high.
- `wr_data` input, 8 bits: write pixel. Must be stable while `wr_req` is high.
- `wr_ack` output, 1 bit: one-cycle pulse that completes the write handshake.
- `wr_err` output, 1 bit: sticky flag for an out-of-range write. Cleared only by `rst`.
- `mem_addr` output, 15 bits: RAM address.
- `mem_we` output, 1 bit: RAM write enable.
- `mem_wdata` output, 8 bits: RAM write data.
- `mem_rdata` input, 8 bits: RAM read data, valid one clk after the address is presented.
- `pixel_out` output, 8 bits: pixel to the DAC or colour mapper.
- `frame_start` output, 1 bit: one-cycle pulse at the start of each frame.

## Operation
- **Slot counter** (2 bits):
  - Forced to 0 on each `pix_ce` cycle; otherwise increments and saturates at 3.
  - Slot 0 is the display slot. Slots 1-3 are writer slots.
- **Visibility:**
  - x = `haddress` - `H_VIS_START`, y = `vaddress` - `V_VIS_START`.
  - `visible` = (0 ≤ x < 640) and (0 ≤ y < 480), evaluated on the `pix_ce` cycle.
- **Display read** (slot 0 only, when `visible`):
  - `mem_addr` = (y>>2)*160 + (x>>2), computed as (r<<7)+(r<<5)+c. Range 0..19199.
  - `mem_we` = 0.
- **Writer grant:**
  - Granted in any cycle with `wr_req`=1 and no display read in that cycle. This covers slots 1-3, plus slot 0 when not `visible`.
  - In a grant cycle: `mem_addr`=`wr_addr`, `mem_wdata`=`wr_data`, `mem_we`=1, `wr_ack`=1.
- **Out-of-range write** (`wr_addr` ≥ 19200): `wr_ack`=1, `mem_we`=0, `wr_err` set.
- **Back-to-back writes:** a writer that keeps `wr_req` high after `wr_ack` with new address and data is granted again the very next eligible cycle. Maximum rate is 3 writes per pixel period in the visible area and 4 in blanking.
- **Idle cycles:** `mem_we`=0; `mem_addr` holds its previous value.
- **Pixel output:**
  - On the cycle after a display read, `mem_rdata` is latched into `pixel_out`.
  - If the slot-0 cycle was not `visible`, `pixel_out` is loaded with 0 on that same following cycle.
  - `pixel_out` is held until the next update.
- **Frame start:** `frame_start` pulses on the `pix_ce` cycle where `haddress`=0 and `vaddress`=0.
- **Late `pix_ce`** (slot counter already saturated at 3): no slot 0 is generated until `pix_ce` arrives. Writer grants continue.

## Timing
- **Reset values:** `pixel_out`=0, `wr_ack`=0, `wr_err`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `frame_start`=0, slot counter=3.
- **Display latency:** address is presented combinationally/registered in the `pix_ce` cycle (cycle k). `mem_rdata` is sampled at cycle k+1. `pixel_out` is valid from cycle k+2 for a full pixel period.
- **Write latency:** `wr_ack` and `mem_we` appear in the same cycle, 0 cycles after an eligible `wr_req`. The worst case is 1 cycle, when the request lands on a visible slot 0.
- **Simultaneous events:**
  - Display read always wins slot 0 when `visible`.
  - `rst` overrides everything.
- **Reset mid-handshake:** a pending request is not acknowledged and no write is performed. The writer keeps `wr_req` high and is served after reset.

## Test plan
- **Reset:** assert `rst` for 3 cycles with `wr_req`=1 -> all outputs 0 and no `mem_we`. First grant occurs the cycle after `rst` falls.
- **Visible scan:** `haddress`=144..151, `vaddress`=35, RAM[0]=0x11, RAM[1]=0x22 -> `pixel_out`=0x11 for 4 pixels, then 0x22. Each update is 2 clk after its `pix_ce`.
- **Blanking:** `haddress`=50, `vaddress`=100 -> `pixel_out`=0 and no display read. A continuous writer gets 4 acks per `pix_ce` period.
- **Contention:** writer request held through the visible area -> exactly 3 acks per pixel period and never `mem_we` on slot 0. RAM readback matches all written data.
- **Out-of-range write:** `wr_addr`=19200 -> `wr_ack` pulses, `mem_we`=0, `wr_err`=1 and stays 1 until `rst`.
- **Frame and address corners:** `haddress`=0, `vaddress`=0 -> `frame_start` pulses once per frame. `haddress`=783, `vaddress`=514 -> `mem_addr`=19199.
